wb_bram_burst: RTL and testbench

//  Wishbone slave block RAM, successor to the single-beat BRAM: parametrised data width and depth,

---
 rtl/wb_bram_pkg.sv | 24 ++
 rtl/wb_burst_adr_gen.sv | 36 +++
 rtl/wb_bram_burst.sv | 131 +++++++++++++
 tb/tb_wb_bram_burst.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// Shared types and burst address arithmetic for the Wishbone burst block RAM.
package wb_bram_pkg;

  typedef enum logic [2:0] {CLASSIC = 3'b000, INCR = 3'b010, EOB = 3'b111} cti_t;
  typedef enum logic [1:0] {LINEAR = 2'b00, WRAP4 = 2'b01, WRAP8 = 2'b10, WRAP16 = 2'b11} bte_t;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Word index after w for the given burst type; result masked to aw bits so a
  // linear burst rolls over to word 0 and never leaves the array.
  function automatic logic [31:0] next_widx(input logic [31:0] w, input bte_t b,
                                            input int unsigned aw);
    logic [31:0] n;
    n = w;
    case (b)
      LINEAR: n = w + 32'd1;
      WRAP4:  n[1:0] = w[1:0] + 2'd1;
      WRAP8:  n[2:0] = w[2:0] + 3'd1;
      WRAP16: n[3:0] = w[3:0] + 4'd1;
      default: n = w;
    endcase
    return n & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Burst word-address register: loads the successor of the start word, then
// advances one word per beat according to the burst type.
module wb_burst_adr_gen
  import wb_bram_pkg::*;
#(
  parameter int MEM_ADR_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     load_i,
  input  logic                     adv_i,
  input  logic [MEM_ADR_WIDTH-1:0] widx_i,
  input  bte_t                     bte_i,
  output logic [MEM_ADR_WIDTH-1:0] badr_o
);

  logic [MEM_ADR_WIDTH-1:0] badr_q, badr_d, src;
  logic [31:0]              nxt;
  logic                     unused_nxt_hi;

  always_comb begin
    src    = load_i ? widx_i : badr_q;
    nxt    = next_widx(32'(src), bte_i, MEM_ADR_WIDTH);
    badr_d = (load_i || adv_i) ? nxt[MEM_ADR_WIDTH-1:0] : badr_q;
  end

  assign unused_nxt_hi = ^nxt[31:MEM_ADR_WIDTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) badr_q <= '0;
    else          badr_q <= badr_d;
  end

  assign badr_o = badr_q;

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone slave block RAM with byte-lane writes, registered-feedback read
// bursts (linear / wrap4/8/16) and an error response beyond the array.
module wb_bram_burst
  import wb_bram_pkg::*;
#(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_BYTES    = 4,
  parameter int ADR_WIDTH     = 32,
  parameter int BURST_EN      = 1,
  localparam int DW           = 8 * DATA_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [DATA_BYTES-1:0] sel_i,
  input  logic [DW-1:0]         dat_ms_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic [DW-1:0]         dat_sm_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int AL    = $clog2(DATA_BYTES);
  localparam int TOP   = MEM_ADR_WIDTH + AL;
  localparam int DEPTH = 2 ** MEM_ADR_WIDTH;

  logic [DATA_BYTES-1:0][7:0] mem_q [DEPTH];
  logic [DW-1:0]              dat_q;
  state_t                     state_q, state_d;
  logic                       ack_q, ack_d;
  logic                       req, oor, wr_en, rd_en, is_incr, load, adv;
  logic [MEM_ADR_WIDTH-1:0]   widx, badr, rd_idx;

  assign req  = cyc_i & stb_i;
  assign widx = adr_i[TOP-1:AL];

  generate
    if (ADR_WIDTH > TOP) begin : g_oor
      assign oor = |adr_i[ADR_WIDTH-1:TOP];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
    if (AL > 0) begin : g_lo
      logic unused_adr_lo;
      assign unused_adr_lo = ^adr_i[AL-1:0];
    end
  endgenerate

  assign is_incr = (BURST_EN != 0) && (cti_i == INCR);
  assign wr_en   = req & we_i & ~oor;
  assign err_o   = req & oor;
  assign ack_o   = wr_en | (ack_q & req & ~we_i);

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rd_en   = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !we_i && !oor && !ack_q) begin
          rd_en = 1'b1;
          ack_d = 1'b1;
          if (is_incr) begin
            state_d = BURST;
            load    = 1'b1;
          end
        end
      end
      BURST: begin
        // ack_q is high for the beat on the bus; a non-INCR cti marks it last.
        if (req && !we_i) begin
          if (is_incr) begin
            rd_en = 1'b1;
            ack_d = 1'b1;
            adv   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  wb_burst_adr_gen #(.MEM_ADR_WIDTH(MEM_ADR_WIDTH)) u_adr_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (load),
    .adv_i   (adv),
    .widx_i  (widx),
    .bte_i   (bte_t'(bte_i)),
    .badr_o  (badr)
  );

  assign rd_idx = (state_q == BURST) ? badr : widx;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (sel_i[b]) mem_q[widx][b] <= dat_ms_i[8*b +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   dat_q <= '0;
    else if (rd_en) dat_q <= mem_q[rd_idx];
  end

  assign dat_sm_o = dat_q;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Randomized check of wb_bram_burst against a word-array reference model.
module tb_wb_bram_burst;
  localparam int AW = 11, DB = 4, DW = 32, ADRW = 32, DEPTH = 2048;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [ADRW-1:0] adr;
  logic [DB-1:0]   sel;
  logic [DW-1:0]   dat_ms, dat_sm;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack, err;

  logic [DW-1:0] model [DEPTH];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_bram_burst #(.MEM_ADR_WIDTH(AW), .DATA_BYTES(DB), .ADR_WIDTH(ADRW), .BURST_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_ms_i(dat_ms), .cti_i(cti), .bte_i(bte),
    .dat_sm_o(dat_sm), .ack_o(ack), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_ms = '0; cti = 3'b000; bte = 2'b00;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DB-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DB; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_oor(input logic [ADRW-1:0] a);
    return (a >> (AW + 2)) != 0;
  endfunction

  // Word visited on beat k of a burst starting at word s.
  function automatic int exp_word(input int s, input int b, input int k);
    int n, base;
    if (b == 0) return (s + k) % DEPTH;
    n    = 2 << b;
    base = s - (s % n);
    return base + ((s % n) + k) % n;
  endfunction

  task automatic wr(input logic [ADRW-1:0] a, input logic [DB-1:0] s, input logic [DW-1:0] d,
                    input bit check);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; sel = s; dat_ms = d; cti = 3'b000;
    #1;
    if (check) begin
      chk("wr_ack", ack, !is_oor(a));
      chk("wr_err", err, is_oor(a));
    end
    if (!is_oor(a)) model[a[AW+1:2]] = merge(model[a[AW+1:2]], d, s);
  endtask

  // Classic read; stb stays high so consecutive calls form back-to-back reads.
  task automatic rd(input logic [ADRW-1:0] a);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; cti = 3'b000;
    #1;
    chk("rd_ack0", ack, 0);
    chk("rd_err0", err, is_oor(a));
    @(negedge clk);
    #1;
    if (is_oor(a)) begin
      chk("rd_oor_ack", ack, 0);
      chk("rd_oor_err", err, 1);
    end else begin
      chk("rd_ack1", ack, 1);
      chk("rd_dat", dat_sm, model[a[AW+1:2]]);
    end
  endtask

  // Starts a burst at word s and runs nb acked beats (nb>=1) with cti=010.
  task automatic burst_beats(input int s, input int b, input int nb, input bit last);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = ADRW'(s) << 2; cti = 3'b010; bte = 2'(b);
    #1;
    chk("bst_ack0", ack, 0);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      adr = ADRW'(exp_word(s, b, k)) << 2;
      cti = (last && k == nb - 1) ? 3'b111 : 3'b010;
      #1;
      chk("bst_ack", ack, 1);
      chk("bst_dat", dat_sm, model[exp_word(s, b, k)]);
    end
  endtask

  task automatic burst(input int s, input int b, input int nb);
    burst_beats(s, b, nb, 1);
    @(negedge clk);
    bus_idle();
    #1;
    chk("bst_end", ack, 0);
  endtask

  initial begin
    logic [DW-1:0] keep0;
    bus_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", dat_sm, 0);
    @(negedge clk);
    rst_n = 1;

    for (int w = 0; w < DEPTH; w++) wr(ADRW'(w) << 2, 4'hF, $urandom, 0);

    // Byte-lane merge
    wr(32'h10, 4'hF, 32'hDEADBEEF, 1);
    wr(32'h10, 4'b0010, 32'h0000AA00, 1);
    rd(32'h10);
    chk("t1_merge", dat_sm, 32'hDEADAAEF);

    // Back-to-back classic reads
    rd(32'h0); rd(32'h4); rd(32'h8);
    @(negedge clk); bus_idle();

    // Linear rollover and wrap bursts
    burst(2046, 0, 4);
    burst(6, 1, 4);
    burst(13, 2, 6);
    burst(21, 3, 16);

    // Out-of-range accesses leave memory intact
    keep0 = model[0];
    wr(32'h2000, 4'hF, ~keep0, 1);
    @(negedge clk); bus_idle();
    rd(32'h2000);
    rd(32'h0);
    chk("oor_keep", dat_sm, keep0);
    @(negedge clk); bus_idle();

    // Read the same word that was just written: write lands, later read sees it
    wr(32'h40, 4'hF, 32'h12345678, 1);
    rd(32'h40);
    @(negedge clk); bus_idle();

    // Abort by dropping stb mid-burst
    burst_beats(100, 0, 2, 0);
    @(negedge clk);
    stb = 0;
    #1;
    chk("abort_ack", ack, 0);
    @(negedge clk);
    bus_idle();
    #1;
    chk("abort_ack2", ack, 0);
    rd(32'h0C);
    @(negedge clk); bus_idle();

    // Reset mid-burst
    burst_beats(200, 2, 2, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rstb_ack", ack, 0);
    chk("rstb_dat", dat_sm, 0);
    @(negedge clk);
    rst_n = 1;
    bus_idle();
    rd(32'h20);
    @(negedge clk); bus_idle();

    // Random mix
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 3) begin
        wr(ADRW'($urandom_range(0, DEPTH - 1)) << 2, 4'($urandom), $urandom, 1);
      end else if (op < 5) begin
        rd(ADRW'($urandom_range(0, DEPTH - 1)) << 2);
      end else if (op < 9) begin
        @(negedge clk); bus_idle();
        burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 3), $urandom_range(2, 10));
      end else begin
        if ($urandom_range(0, 1) == 1) wr(32'h4000 | (ADRW'($urandom_range(0, 255)) << 2), 4'hF, $urandom, 1);
        else rd(32'h8000_0000 | (ADRW'($urandom_range(0, 255)) << 2));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); bus_idle();
      end
    end
    @(negedge clk); bus_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
